// File: rtl/board_io.sv
// board_io: board-side I/O port for the single-cycle CPU.
// Synchronises and debounces 24 slide switches onto io_rdata and latches
// io_wdata into a 24-bit LED register on each I/O write strobe.
// Optional seven-segment scanner compiled in with BOARD_IO_SEG7_EN.
module board_io #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SCAN_CYCLES     = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_read,
  input  logic        io_write,
  input  logic [23:0] io_wdata,
  output logic [23:0] io_rdata,
  input  logic [23:0] switch,
  output logic [23:0] led
`ifdef BOARD_IO_SEG7_EN
  ,
  output logic [5:0]  seg_an,
  output logic [7:0]  seg_cat
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [23:0]   s1_q, s2_q, cand_q, stable_q, led_q;
  logic [23:0]   cand_d, stable_d, led_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Debounce rules and LED write, in priority order
  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cand_q != stable_q && cnt_q == CNT_LAST) begin
      stable_d = cand_q;
      cnt_d    = '0;
    end else if (cand_q != stable_q) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end
    led_d = io_write ? io_wdata : led_q;
  end

  // Synchroniser, debounce state and LED register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      led_q    <= '0;
    end else begin
      s1_q     <= switch;
      s2_q     <= s1_q;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
    end
  end

  // Read gating is purely combinational; reads have no side effects
  always_comb begin
    io_rdata = io_read ? stable_q : '0;
    led      = led_q;
  end

`ifdef BOARD_IO_SEG7_EN
  localparam int SW = $clog2(SCAN_CYCLES);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]    dig_q, dig_d;
  logic [23:0]   led_sh;
  logic [3:0]    nib;

  // Slot counter and digit index advance
  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    dig_d      = dig_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      dig_d      = (dig_q == 3'd5) ? 3'd0 : dig_q + 3'd1;
    end
  end

  // Scanner state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= '0;
      dig_q      <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      dig_q      <= dig_d;
    end
  end

  // Anode select and hex decode of the current nibble (dp off)
  always_comb begin
    led_sh = led_q >> {dig_q, 2'b00};
    nib    = led_sh[3:0];
    case (dig_q)
      3'd0:    seg_an = 6'b111110;
      3'd1:    seg_an = 6'b111101;
      3'd2:    seg_an = 6'b111011;
      3'd3:    seg_an = 6'b110111;
      3'd4:    seg_an = 6'b101111;
      3'd5:    seg_an = 6'b011111;
      default: seg_an = 6'b111111;
    endcase
    case (nib)
      4'h0: seg_cat = 8'hC0;
      4'h1: seg_cat = 8'hF9;
      4'h2: seg_cat = 8'hA4;
      4'h3: seg_cat = 8'hB0;
      4'h4: seg_cat = 8'h99;
      4'h5: seg_cat = 8'h92;
      4'h6: seg_cat = 8'h82;
      4'h7: seg_cat = 8'hF8;
      4'h8: seg_cat = 8'h80;
      4'h9: seg_cat = 8'h90;
      4'hA: seg_cat = 8'h88;
      4'hB: seg_cat = 8'h83;
      4'hC: seg_cat = 8'hC6;
      4'hD: seg_cat = 8'hA1;
      4'hE: seg_cat = 8'h86;
      default: seg_cat = 8'h8E;
    endcase
  end
`endif

endmodule

// File: doc/board_io.md
# board_io

Board-side I/O port for the single-cycle CPU. It synchronises and debounces the 24 slide switches and presents them on the CPU's `io_rdata` input, and it latches the CPU's `io_wdata` into a 24-bit LED register on each I/O write strobe. It sits directly downstream of the CPU's memory/IO router (consuming `io_wdata`) and directly upstream of it (producing `io_rdata`).

## Interface
- `DEBOUNCE_CYCLES`, default 20000: number of clock cycles the synchronised switch vector must hold a new value before it is accepted; minimum 2.
- `SCAN_CYCLES`, default 100000: clock cycles per seven-segment digit slot; only used with `BOARD_IO_SEG7_EN`; minimum 2.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `io_read` input 1: CPU I/O read strobe.
- `io_write` input 1: CPU I/O write strobe.
- `io_wdata` input 24: data from the CPU to the LEDs.
- `io_rdata` output 24: debounced switch value returned to the CPU.
- `switch` input 24: raw, asynchronous board switches.
- `led` output 24: LED register.
- `seg_an` output 6: digit anodes, active-low one-hot; present only with `BOARD_IO_SEG7_EN`.
- `seg_cat` output 8: segments `{dp,g,f,e,d,c,b,a}`, active-low; present only with `BOARD_IO_SEG7_EN`.

## Operation
- **Synchroniser.** Two flops per switch bit (`s1`, `s2`), reset to 0.
- **Debounce state.**
  - `cand` (24), `stable` (24), reset to 0.
  - `cnt`, width `$clog2(DEBOUNCE_CYCLES)`, reset to 0.
- **Debounce rules**, evaluated each cycle in priority order:
  - If `s2 != cand`: `cand <= s2`, `cnt <= 0`.
  - Else if `cand != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= cand`, `cnt <= 0`.
  - Else if `cand != stable`: `cnt <= cnt+1`.
  - Else: `cnt <= 0`.
- **Read path.** `io_rdata = io_read ? stable : 24'h0`, combinational from registers. No read side effects.
- **Write path.** When `io_write=1`, `led <= io_wdata`; otherwise `led` holds. `led` resets to 0.
- **Simultaneous events.** `io_read` and `io_write` in the same cycle are serviced independently. Switch and LED paths do not interact.
- **Reset mid-debounce.** `rst` abandons any pending value. After release, the debounce restarts from `stable=0`.

## Timing
- **Reset values.** `io_rdata=0`, `led=0`, `seg_an=6'b111110`, `seg_cat` shows the digit 0 pattern of `led[3:0]=0`, i.e. `8'hC0`.
- **Switch latency.** A switch change held steady first appears in `stable` on rising edge `DEBOUNCE_CYCLES+3` after the first sampling edge:
  - 2 edges through the synchroniser;
  - 1 edge to load `cand`;
  - `DEBOUNCE_CYCLES` edges of count/commit.
- **Glitch rejection.** Any change lasting fewer than `DEBOUNCE_CYCLES+1` cycles never reaches `stable`.
- **Bounce.** Any intermediate difference restarts the count.
- **LED latency.** `led` updates on the same edge that samples `io_write=1`, so the CPU's store is visible 1 cycle later.
- **Read latency.** `io_rdata` is valid combinationally in the same cycle as `io_read`.

## Configuration
- **With `BOARD_IO_SEG7_EN` defined:** a display scanner is compiled in.
  - `scan_cnt` counts 0 to `SCAN_CYCLES-1` and wraps.
  - At the wrap, digit index `dig` advances 0→5, then wraps to 0. Both reset to 0.
  - `seg_an[dig]=0`; all other anode bits are 1.
  - `seg_cat` is the active-low hex pattern of `led[4*dig+3:4*dig]`, with dp=1 (off).
  - Patterns for 0–F: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90, 88, 83, C6, A1, 86, 8E.
  - The display reflects `led` combinationally.
- **Without the macro:** the scanner, `seg_an` and `seg_cat` are absent. Switch and LED behaviour is identical.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `SCAN_CYCLES=3`.
1. **Reset.** Hold `rst=1` with `switch=24'hFFFFFF`, `io_write=1`, `io_wdata=24'h123456`, `io_read=1` → `led=0`, `io_rdata=0`. Keep `switch` held after release → `io_rdata=24'hFFFFFF` exactly 7 edges after release.
2. **Debounce latency.** From `stable=0`, set `switch=24'h00A5A5` with `io_read=1` → `io_rdata=0` through edge 6, `24'h00A5A5` from edge 7.
3. **Glitch rejection.** Pulse `switch=24'h000001` for 3 cycles, then return to 0 → `io_rdata` stays 0 for 20 cycles.
4. **LED write.** `io_write=1`, `io_wdata=24'h123456` for one cycle → `led=24'h123456` after that edge. Then `io_write=0`, `io_wdata=24'hFFFFFF` → `led` unchanged.
5. **Read gating.** `io_read=0` with `stable=24'h00A5A5` → `io_rdata=0`. Set `io_read=1` and `io_write=1` in the same cycle → both paths behave as in scenarios 2 and 4.
6. **Display scan** (`BOARD_IO_SEG7_EN`). Write `led=24'h00000A` → `seg_an=6'b111110`, `seg_cat=8'h88`. 3 cycles later → `seg_an=6'b111101`, `seg_cat=8'hC0`. 18 cycles after the first → back to digit 0.
